// File: rtl/ttio_icb_cmd_buf_if.sv
// rtl/ttio_icb_cmd_buf_if.sv - ICB command/response bundle between TTIO, the command buffer and LSU-ctrl
//
// One instance carries one ICB link: the command channel (valid/ready plus
// payload) flowing from master to slave, and the response channel
// (valid/ready plus err/rdata) flowing back.
//   master : drives cmd_* payload, cmd_valid and rsp_ready
//   slave  : drives cmd_ready, rsp_valid, rsp_err and rsp_rdata
interface ttio_icb_cmd_buf_if #(
    parameter int ITAG_W = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_addr;
    logic              cmd_read;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wmask;
    logic [1:0]        cmd_size;
    logic              cmd_usign;
    logic [ITAG_W-1:0] cmd_itag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
               cmd_size, cmd_usign, cmd_itag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
               cmd_size, cmd_usign, cmd_itag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/ttio_icb_cmd_buf.sv
// rtl/ttio_icb_cmd_buf.sv - TTIO ICB command FIFO with outstanding-transaction cap and flush
//
// Ports:
//   clk         core clock
//   rst_n       asynchronous active-low reset
//   i_icb       slave side, from the TTIO ICB master (commands in, responses out)
//   o_icb       master side, towards LSU-ctrl (commands out, responses in)
//   flush_pulse one-cycle flush from commit; drops queued, not yet issued commands
//   buf_idle    FIFO empty and nothing outstanding at LSU-ctrl
module ttio_icb_cmd_buf #(
    parameter int DEPTH    = 2,
    parameter int OUTS_MAX = 2,
    parameter int ITAG_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ttio_icb_cmd_buf_if.slave  i_icb,
    ttio_icb_cmd_buf_if.master o_icb,
    input  logic               flush_pulse,
    output logic               buf_idle
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OUTS_W = 4;
    localparam int ENT_W  = 32 + 1 + 32 + 4 + 2 + 1 + ITAG_W;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [OUTS_W-1:0] outs_cnt;
    logic              empty;
    logic              full;
    logic              cap_ok;
    logic              push;
    logic              pop;
    logic              rsp_hs;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_W'(DEPTH));
    assign cap_ok = (outs_cnt < OUTS_W'(OUTS_MAX));

    // Ready depends only on local state and flush, never on o_cmd_ready:
    // a full FIFO does not accept even when the head is leaving this cycle.
    assign i_icb.cmd_ready = ~full & ~flush_pulse;
    assign o_icb.cmd_valid = ~empty & cap_ok & ~flush_pulse;

    assign push   = i_icb.cmd_valid & i_icb.cmd_ready;
    assign pop    = o_icb.cmd_valid & o_icb.cmd_ready;
    assign rsp_hs = o_icb.rsp_valid & i_icb.rsp_ready;

    // Payload storage carries no reset; only the bookkeeping below is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_icb.cmd_addr, i_icb.cmd_read, i_icb.cmd_wdata,
                            i_icb.cmd_wmask, i_icb.cmd_size, i_icb.cmd_usign,
                            i_icb.cmd_itag};
        end
    end

    // Head is always read from storage, so a command needs at least one
    // edge to get from i_cmd_* to o_cmd_*.
    assign head = mem[rd_ptr];
    assign {o_icb.cmd_addr, o_icb.cmd_read, o_icb.cmd_wdata, o_icb.cmd_wmask,
            o_icb.cmd_size, o_icb.cmd_usign, o_icb.cmd_itag} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_pulse) begin
            // push and pop are both blocked during flush, so nothing is lost
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Outstanding count is independent of flush: issued commands still
    // owe a response. A stray response at zero leaves the count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_cnt <= '0;
        end else if (pop && !rsp_hs) begin
            outs_cnt <= outs_cnt + OUTS_W'(1);
        end else if (rsp_hs && !pop && (outs_cnt != '0)) begin
            outs_cnt <= outs_cnt - OUTS_W'(1);
        end
    end

    // Response path is pure wiring; LSU-ctrl returns in issue order.
    assign i_icb.rsp_valid = o_icb.rsp_valid;
    assign i_icb.rsp_err   = o_icb.rsp_err;
    assign i_icb.rsp_rdata = o_icb.rsp_rdata;
    assign o_icb.rsp_ready = i_icb.rsp_ready;

    assign buf_idle = empty & (outs_cnt == '0);

    a_rsp_without_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) rsp_hs |-> (outs_cnt != '0)
    );

    a_outs_capped: assert property (
        @(posedge clk) disable iff (!rst_n) outs_cnt <= OUTS_W'(OUTS_MAX)
    );
endmodule

// File: tb/tb_ttio_icb_cmd_buf.sv
// tb/tb_ttio_icb_cmd_buf.sv - directed testbench for ttio_icb_cmd_buf with command scoreboard
module tb_ttio_icb_cmd_buf;
    logic clk = 1'b0;
    logic rst_n;
    logic flush_pulse;
    logic buf_idle;

    ttio_icb_cmd_buf_if #(.ITAG_W(1)) i_icb ();
    ttio_icb_cmd_buf_if #(.ITAG_W(1)) o_icb ();

    ttio_icb_cmd_buf #(.DEPTH(2), .OUTS_MAX(2), .ITAG_W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_icb       (i_icb),
        .o_icb       (o_icb),
        .flush_pulse (flush_pulse),
        .buf_idle    (buf_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  size;
        logic        usign;
        logic        itag;
    } cmd_t;

    cmd_t sb[$];
    cmd_t mon_e;
    cmd_t mon_d;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_iss  = 0;
    int   m_outs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [31:0] addr, input logic read, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [1:0] size, input logic usign,
                           input logic itag);
        i_icb.cmd_addr  = addr;
        i_icb.cmd_read  = read;
        i_icb.cmd_wdata = wdata;
        i_icb.cmd_wmask = wmask;
        i_icb.cmd_size  = size;
        i_icb.cmd_usign = usign;
        i_icb.cmd_itag  = itag;
    endtask

    task automatic idle_inputs();
        i_icb.cmd_valid = 1'b0;
        set_cmd(32'h0, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        i_icb.rsp_ready = 1'b0;
        o_icb.cmd_ready = 1'b0;
        o_icb.rsp_valid = 1'b0;
        o_icb.rsp_err   = 1'b0;
        o_icb.rsp_rdata = 32'h0;
        flush_pulse     = 1'b0;
    endtask

    // Called just after an edge; one response handshake, returns just after the next edge.
    task automatic respond(input logic [31:0] rd, input logic err, input string tag);
        o_icb.rsp_valid = 1'b1;
        o_icb.rsp_rdata = rd;
        o_icb.rsp_err   = err;
        i_icb.rsp_ready = 1'b1;
        smp();
        chk({tag, "_vld"},   i_icb.rsp_valid, 1);
        chk({tag, "_rdata"}, i_icb.rsp_rdata, rd);
        chk({tag, "_err"},   i_icb.rsp_err, err);
        chk({tag, "_ordy"},  o_icb.rsp_ready, 1);
        step();
        o_icb.rsp_valid = 1'b0;
        o_icb.rsp_err   = 1'b0;
        i_icb.rsp_ready = 1'b0;
    endtask

    // Scoreboard monitor: looks at handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_outs = 0;
        end else begin
            if (o_icb.cmd_valid === 1'b1 && o_icb.cmd_ready === 1'b1) begin
                n_iss++;
                chk("iss_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("iss_addr",  o_icb.cmd_addr, mon_e.addr);
                    chk("iss_wdata", o_icb.cmd_wdata, mon_e.wdata);
                    chk("iss_ctl", {o_icb.cmd_read, o_icb.cmd_wmask, o_icb.cmd_size,
                                    o_icb.cmd_usign, o_icb.cmd_itag},
                                   {mon_e.read, mon_e.wmask, mon_e.size, mon_e.usign, mon_e.itag});
                end
                m_outs++;
            end
            if (flush_pulse) begin
                sb.delete();
            end
            if (i_icb.cmd_valid && i_icb.cmd_ready === 1'b1) begin
                mon_d = '{i_icb.cmd_addr, i_icb.cmd_read, i_icb.cmd_wdata, i_icb.cmd_wmask,
                          i_icb.cmd_size, i_icb.cmd_usign, i_icb.cmd_itag};
                sb.push_back(mon_d);
            end
            if (o_icb.rsp_valid && i_icb.rsp_ready && m_outs > 0) begin
                m_outs--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int cyc;
        int iss0;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        smp();
        chk("rst_ovalid", o_icb.cmd_valid, 0);
        chk("rst_irdy",   i_icb.cmd_ready, 1);
        chk("rst_idle",   buf_idle, 1);
        step();
        rst_n = 1'b1;

        // Back-pressure and full
        step();
        o_icb.cmd_ready = 1'b0;
        set_cmd(32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 2'b10, 1'b0, 1'b0);
        i_icb.cmd_valid = 1'b1;
        smp();
        chk("t2_irdy_empty", i_icb.cmd_ready, 1);
        chk("t2_no_bypass",  o_icb.cmd_valid, 0);
        step();
        set_cmd(32'h104, 1'b0, 32'hCAFEF00D, 4'h3, 2'b01, 1'b0, 1'b1);
        smp();
        chk("t2_ovalid",   o_icb.cmd_valid, 1);
        chk("t2_head0",    o_icb.cmd_addr, 32'h100);
        chk("t2_irdy_one", i_icb.cmd_ready, 1);
        step();
        i_icb.cmd_valid = 1'b0;
        smp();
        chk("t2_full",  i_icb.cmd_ready, 0);
        chk("t2_hold1", o_icb.cmd_addr, 32'h100);
        step();
        smp();
        chk("t2_hold2",       o_icb.cmd_addr, 32'h100);
        chk("t2_hold2_wdata", o_icb.cmd_wdata, 32'hDEADBEEF);
        step();
        o_icb.cmd_ready = 1'b1;
        smp();
        chk("t2_hs_addr", o_icb.cmd_addr, 32'h100);
        step();
        smp();
        chk("t2_next_addr", o_icb.cmd_addr, 32'h104);
        chk("t2_irdy_free", i_icb.cmd_ready, 1);
        step();
        o_icb.cmd_ready = 1'b0;
        smp();
        chk("t2_drained_ovalid", o_icb.cmd_valid, 0);
        chk("t2_busy",           buf_idle, 0);
        step();
        respond(32'h11111111, 1'b0, "t2_r0");
        respond(32'h22222222, 1'b0, "t2_r1");
        smp();
        chk("t2_idle", buf_idle, 1);

        // Outstanding cap
        step();
        o_icb.cmd_ready = 1'b1;
        set_cmd(32'h200, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 1'b0);
        i_icb.cmd_valid = 1'b1;
        step();
        set_cmd(32'h204, 1'b1, 32'h0, 4'h0, 2'b01, 1'b1, 1'b1);
        step();
        set_cmd(32'h208, 1'b1, 32'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        step();
        i_icb.cmd_valid = 1'b0;
        smp();
        chk("t3_capped",  o_icb.cmd_valid, 0);
        chk("t3_busy",    buf_idle, 0);
        step();
        smp();
        chk("t3_capped2", o_icb.cmd_valid, 0);
        step();
        o_icb.rsp_valid = 1'b1;
        o_icb.rsp_rdata = 32'hAAAA0001;
        i_icb.rsp_ready = 1'b1;
        smp();
        chk("t3_capped_rsp", o_icb.cmd_valid, 0);
        step();
        o_icb.rsp_valid = 1'b0;
        i_icb.rsp_ready = 1'b0;
        smp();
        chk("t3_issue",      o_icb.cmd_valid, 1);
        chk("t3_issue_addr", o_icb.cmd_addr, 32'h208);
        step();
        o_icb.cmd_ready = 1'b0;
        respond(32'hAAAA0002, 1'b0, "t3_r1");
        respond(32'hAAAA0003, 1'b0, "t3_r2");
        smp();
        chk("t3_idle", buf_idle, 1);

        // Flush with 2 queued and 1 outstanding
        step();
        o_icb.cmd_ready = 1'b1;
        set_cmd(32'h300, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 1'b0);
        i_icb.cmd_valid = 1'b1;
        step();
        set_cmd(32'h304, 1'b0, 32'h01020304, 4'hC, 2'b01, 1'b0, 1'b1);
        step();
        o_icb.cmd_ready = 1'b0;
        set_cmd(32'h308, 1'b0, 32'h05060708, 4'h1, 2'b00, 1'b0, 1'b0);
        step();
        set_cmd(32'h3FC, 1'b0, 32'h0BADF00D, 4'hF, 2'b10, 1'b0, 1'b0);
        smp();
        chk("t4_full", i_icb.cmd_ready, 0);
        step();
        flush_pulse = 1'b1;
        smp();
        chk("t4_fl_ovalid", o_icb.cmd_valid, 0);
        chk("t4_fl_irdy",   i_icb.cmd_ready, 0);
        step();
        flush_pulse     = 1'b0;
        i_icb.cmd_valid = 1'b0;
        smp();
        chk("t4_empty_ovalid", o_icb.cmd_valid, 0);
        chk("t4_empty_irdy",   i_icb.cmd_ready, 1);
        chk("t4_busy",         buf_idle, 0);
        step();
        respond(32'h12345678, 1'b0, "t4_rsp");
        smp();
        chk("t4_idle", buf_idle, 1);
        step();
        o_icb.cmd_ready = 1'b1;
        set_cmd(32'h400, 1'b0, 32'h44440000, 4'h6, 2'b01, 1'b0, 1'b1);
        i_icb.cmd_valid = 1'b1;
        step();
        i_icb.cmd_valid = 1'b0;
        smp();
        chk("t4_after_valid", o_icb.cmd_valid, 1);
        step();
        o_icb.cmd_ready = 1'b0;
        respond(32'h44444444, 1'b0, "t4_w_rsp");

        // Wrap-around streaming with random back-pressure
        iss0 = n_iss;
        k    = 0;
        cyc  = 0;
        while ((k < 8 || sb.size() != 0 || m_outs > 0) && cyc < 300) begin
            step();
            if (k < 8) begin
                set_cmd(32'h1000 + 32'(k) * 4, logic'(k[0]), 32'hA5A50000 ^ (32'(k) * 32'h01010101),
                        4'(1 << (k % 4)), 2'(k % 3), logic'(k[1]), logic'(k[0]));
                i_icb.cmd_valid = 1'b1;
            end else begin
                i_icb.cmd_valid = 1'b0;
            end
            o_icb.cmd_ready = 1'($urandom_range(0, 1));
            o_icb.rsp_valid = (m_outs > 0);
            o_icb.rsp_rdata = $urandom;
            i_icb.rsp_ready = 1'b1;
            smp();
            if (i_icb.cmd_valid && i_icb.cmd_ready) begin
                k++;
            end
            cyc++;
        end
        chk("t5_in_budget", 64'(cyc < 300), 1);
        chk("t5_issued",    64'(n_iss - iss0), 8);
        step();
        idle_inputs();
        smp();
        chk("t5_idle", buf_idle, 1);

        // Error response held under back-pressure
        step();
        o_icb.cmd_ready = 1'b1;
        set_cmd(32'h500, 1'b1, 32'h0, 4'h0, 2'b10, 1'b1, 1'b0);
        i_icb.cmd_valid = 1'b1;
        step();
        i_icb.cmd_valid = 1'b0;
        step();
        o_icb.cmd_ready = 1'b0;
        o_icb.rsp_valid = 1'b1;
        o_icb.rsp_err   = 1'b1;
        o_icb.rsp_rdata = 32'hBAD0BAD0;
        i_icb.rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            smp();
            chk("t6_held_vld",  i_icb.rsp_valid, 1);
            chk("t6_held_err",  i_icb.rsp_err, 1);
            chk("t6_held_ordy", o_icb.rsp_ready, 0);
            chk("t6_held_busy", buf_idle, 0);
            step();
        end
        i_icb.rsp_ready = 1'b1;
        smp();
        chk("t6_hs_ordy",  o_icb.rsp_ready, 1);
        chk("t6_hs_rdata", i_icb.rsp_rdata, 32'hBAD0BAD0);
        step();
        o_icb.rsp_valid = 1'b0;
        o_icb.rsp_err   = 1'b0;
        i_icb.rsp_ready = 1'b0;
        smp();
        chk("t6_idle", buf_idle, 1);

        // Asynchronous reset with 2 queued and 1 outstanding
        step();
        o_icb.cmd_ready = 1'b1;
        set_cmd(32'h600, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 1'b0);
        i_icb.cmd_valid = 1'b1;
        step();
        set_cmd(32'h604, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 1'b1);
        step();
        o_icb.cmd_ready = 1'b0;
        set_cmd(32'h608, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 1'b0);
        step();
        i_icb.cmd_valid = 1'b0;
        smp();
        chk("t1_pre_ovalid", o_icb.cmd_valid, 1);
        chk("t1_pre_full",   i_icb.cmd_ready, 0);
        chk("t1_pre_busy",   buf_idle, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_ovalid", o_icb.cmd_valid, 0);
        chk("t1_rst_irdy",   i_icb.cmd_ready, 1);
        chk("t1_rst_idle",   buf_idle, 1);
        step();
        step();
        rst_n = 1'b1;
        smp();
        chk("t1_post_ovalid", o_icb.cmd_valid, 0);
        chk("t1_post_idle",   buf_idle, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
